// File: rtl/vco_adc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vco_adc_ctrl_pkg
//  Description : Shared types and constants for the VCO-ADC conversion
//                controller (state encoding, default widths).
//  Revision    : 1.0 - initial release
// ============================================================================
package vco_adc_ctrl_pkg;

    // Default width of the window length and of the result count
    localparam int C_CNT_W_DEF = 10;

    // Width of the phase counter timing the VCO reset and settle intervals
    localparam int C_PH_W = 4;

    // Conversion controller states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VRST   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_COUNT  = 3'd3,
        ST_HOLD   = 3'd4
    } state_e;

endpackage : vco_adc_ctrl_pkg
`default_nettype wire

// File: rtl/vco_adc_ctrl_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : vco_adc_cnt
//  Description : Clearable, enabled up-counter. Adds inc on every enabled
//                edge; clear has priority over enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module vco_adc_cnt #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear_i,
    input  logic         enable_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;

    // Count register: async reset, synchronous clear, conditional increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (enable_i && inc_i) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count_o = count_q;

endmodule : vco_adc_cnt
`default_nettype wire

// File: rtl/vco_adc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : vco_adc_ctrl
//  Description : VCO-based ADC conversion controller. Resets the VCO, lets it
//                settle, counts ones of the sampled bitstream over a window
//                and holds the result until the consumer accepts it.
//  Revision    : 1.0 - initial release
// ============================================================================
module vco_adc_ctrl
    import vco_adc_ctrl_pkg::*;
#(
    parameter int CNT_W   = C_CNT_W_DEF,
    parameter int RST_CYC = 2,
    parameter int SETTLE  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] win_len,
    input  logic             d,
    output logic             vco_rst,
    output logic             busy,
    output logic [CNT_W-1:0] result,
    output logic             out_valid,
    input  logic             out_ready
);

    // Terminal phase values for the reset and settle intervals. The settle
    // value is only consulted when the SETTLE state is actually visited.
    localparam logic [C_PH_W-1:0] C_RST_LAST = C_PH_W'(RST_CYC - 1);
    localparam logic [C_PH_W-1:0] C_SET_LAST = C_PH_W'((SETTLE > 0) ? SETTLE - 1 : 0);

    state_e             state_q, state_d;
    logic [C_PH_W-1:0]  phase_q, phase_d;
    logic [CNT_W-1:0]   win_len_q, win_len_d;
    logic               vco_rst_q, busy_q, out_valid_q;

    logic               w_cnt_clr;
    logic               w_cnt_en;
    logic [CNT_W-1:0]   w_ones;
    logic [CNT_W-1:0]   w_samples;
    logic               w_win_empty;
    logic               w_last_sample;

    assign w_win_empty   = (win_len_q == '0);
    assign w_last_sample = ((w_samples + CNT_W'(1)) == win_len_q);

    // Next-state, phase and counter-control decode; abort overrides everything
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        win_len_d = win_len_q;
        w_cnt_clr = 1'b0;
        w_cnt_en  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    win_len_d = win_len;
                    w_cnt_clr = 1'b1;
                    phase_d   = '0;
                    state_d   = ST_VRST;
                end
            end
            ST_VRST: begin
                if (phase_q == C_RST_LAST) begin
                    phase_d = '0;
                    if (SETTLE > 0) begin
                        state_d = ST_SETTLE;
                    end else begin
                        state_d = w_win_empty ? ST_HOLD : ST_COUNT;
                    end
                end else begin
                    phase_d = phase_q + C_PH_W'(1);
                end
            end
            ST_SETTLE: begin
                if (phase_q == C_SET_LAST) begin
                    phase_d = '0;
                    state_d = w_win_empty ? ST_HOLD : ST_COUNT;
                end else begin
                    phase_d = phase_q + C_PH_W'(1);
                end
            end
            ST_COUNT: begin
                w_cnt_en = 1'b1;
                if (w_last_sample) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort discards the conversion, even against a simultaneous accept
        if (abort && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            phase_d   = '0;
            w_cnt_clr = 1'b1;
            w_cnt_en  = 1'b0;
        end
    end

    // State and registered outputs, decoded from the next state so every
    // output changes on the same edge as the state it reflects
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            phase_q     <= '0;
            win_len_q   <= '0;
            vco_rst_q   <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            win_len_q   <= win_len_d;
            vco_rst_q   <= (state_d == ST_VRST);
            busy_q      <= (state_d != ST_IDLE);
            out_valid_q <= (state_d == ST_HOLD);
        end
    end

    // Ones counter: accumulates the sampled bitstream during the window
    vco_adc_cnt #(
        .W (CNT_W)
    ) u_ones_cnt (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (w_cnt_clr),
        .enable_i (w_cnt_en),
        .inc_i    (d),
        .count_o  (w_ones)
    );

    // Sample counter: tracks how many window samples have been taken
    vco_adc_cnt #(
        .W (CNT_W)
    ) u_samp_cnt (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (w_cnt_clr),
        .enable_i (w_cnt_en),
        .inc_i    (1'b1),
        .count_o  (w_samples)
    );

    assign vco_rst   = vco_rst_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign result    = w_ones;

endmodule : vco_adc_ctrl
`default_nettype wire

// File: tb/tb_vco_adc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vco_adc_ctrl
//  Description : Self-checking bench for vco_adc_ctrl: table vectors, random
//                windows against a popcount reference, and hand sequences for
//                abort, async reset and start-while-busy.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vco_adc_ctrl;

    localparam int W = 10;
    localparam int R = 2;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         abort;
    logic [W-1:0] win_len;
    logic         d;
    logic         vco_rst;
    logic         busy;
    logic [W-1:0] result;
    logic         out_valid;
    logic         out_ready;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          wl;
        logic [15:0] pat;
        int          rdly;
        int          exp_res;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    vco_adc_ctrl #(
        .CNT_W   (W),
        .RST_CYC (R),
        .SETTLE  (S)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .win_len   (win_len),
        .d         (d),
        .vco_rst   (vco_rst),
        .busy      (busy),
        .result    (result),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: number of ones among the first n window samples
    function automatic int ref_ones(input logic [1023:0] p, input int n);
        int c = 0;
        for (int i = 0; i < n; i++) c += int'(p[i]);
        return c;
    endfunction

    // One full conversion. Start is accepted at the next edge (edge 0); the
    // window samples are the wl edges ending at edge R+S+wl where out_valid
    // must first appear. Outside the window d is random noise.
    task automatic run_conv(input int wl, input logic [1023:0] pat, input int rdly,
                            input int exp_res, input bit spam, input string nm);
        int lat;
        lat     = R + S + wl;
        start   = 1'b1;
        win_len = W'(wl);
        d       = 1'($urandom_range(0, 1));
        for (int j = 0; j <= lat; j++) begin
            tick;
            chk({nm, ":busy"}, 32'(busy), 32'd1);
            chk({nm, ":vco_rst"}, 32'(vco_rst), 32'(j < R));
            chk({nm, ":valid"}, 32'(out_valid), 32'(j == lat));
            if (spam) begin
                start   = ((j % 3) == 1);
                win_len = W'($urandom);
            end else begin
                start = 1'b0;
            end
            if ((j + 1 > R + S) && (j + 1 <= lat)) d = pat[j - R - S];
            else                                  d = 1'($urandom_range(0, 1));
        end
        chk({nm, ":result"}, 32'(result), 32'(exp_res));
        for (int h = 0; h < rdly; h++) begin
            tick;
            chk({nm, ":hold_valid"}, 32'(out_valid), 32'd1);
            chk({nm, ":hold_result"}, 32'(result), 32'(exp_res));
        end
        out_ready = 1'b1;
        start     = spam;
        tick;
        chk({nm, ":acc_busy"}, 32'(busy), 32'd0);
        chk({nm, ":acc_valid"}, 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        start     = 1'b0;
        tick;
        chk({nm, ":idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [1023:0] p;
        int            wl;

        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        win_len   = '0;
        d         = 1'b0;
        out_ready = 1'b0;

        // Table: window length, sample bits (LSB first), ready delay, expected
        vecs[0] = '{wl: 8,  pat: 16'h00CD, rdly: 0, exp_res: 5};
        vecs[1] = '{wl: 0,  pat: 16'hFFFF, rdly: 0, exp_res: 0};
        vecs[2] = '{wl: 4,  pat: 16'h000F, rdly: 2, exp_res: 4};
        vecs[3] = '{wl: 1,  pat: 16'h0001, rdly: 0, exp_res: 1};
        vecs[4] = '{wl: 5,  pat: 16'hFFF5, rdly: 3, exp_res: 3};
        vecs[5] = '{wl: 16, pat: 16'hFFFF, rdly: 1, exp_res: 16};

        // Reset state
        tick;
        tick;
        chk("rst_vco_rst", 32'(vco_rst), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        rst = 1'b0;
        tick;

        for (int i = 0; i < 6; i++) begin
            p       = '0;
            p[15:0] = vecs[i].pat;
            run_conv(vecs[i].wl, p, vecs[i].rdly, vecs[i].exp_res, 1'b0, $sformatf("vec%0d", i));
        end

        // Full window with backpressure
        p = '1;
        run_conv(1023, p, 10, 1023, 1'b0, "full");

        // Start pulses while busy and on the accept edge
        p       = '0;
        p[15:0] = 16'h00B3;
        run_conv(8, p, 2, 5, 1'b1, "spam");

        // Abort during COUNT at the third sample
        start   = 1'b1;
        win_len = W'(8);
        d       = 1'b1;
        tick;
        start = 1'b0;
        repeat (8) tick;
        chk("abort_pre_busy", 32'(busy), 32'd1);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_vco_rst", 32'(vco_rst), 32'd0);
        p = '1;
        run_conv(4, p, 0, 4, 1'b0, "post_abort");

        // Abort in VRST
        start   = 1'b1;
        win_len = W'(3);
        tick;
        start = 1'b0;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("abort_vrst_vco_rst", 32'(vco_rst), 32'd0);
        chk("abort_vrst_busy", 32'(busy), 32'd0);

        // Abort beats out_ready in HOLD
        start   = 1'b1;
        win_len = W'(2);
        tick;
        start = 1'b0;
        repeat (R + S + 2) tick;
        chk("hold_pre_valid", 32'(out_valid), 32'd1);
        abort     = 1'b1;
        out_ready = 1'b1;
        tick;
        abort     = 1'b0;
        out_ready = 1'b0;
        chk("abort_hold_busy", 32'(busy), 32'd0);
        chk("abort_hold_valid", 32'(out_valid), 32'd0);

        // Start together with abort in IDLE
        start = 1'b1;
        abort = 1'b1;
        tick;
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", 32'(busy), 32'd0);
        tick;
        chk("start_abort_busy2", 32'(busy), 32'd0);

        // Asynchronous reset between edges, mid-VRST
        start   = 1'b1;
        win_len = W'(5);
        tick;
        start = 1'b0;
        chk("arst_pre_vco_rst", 32'(vco_rst), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_vco_rst", 32'(vco_rst), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_result", 32'(result), 32'd0);
        #1 rst = 1'b0;
        tick;
        chk("arst_idle_busy", 32'(busy), 32'd0);
        tick;
        chk("arst_idle_busy2", 32'(busy), 32'd0);

        // Random windows against the popcount reference
        for (int n = 0; n < 20; n++) begin
            wl = int'($urandom_range(0, 40));
            p  = '0;
            for (int i = 0; i < wl; i++) p[i] = 1'($urandom_range(0, 1));
            run_conv(wl, p, int'($urandom_range(0, 3)), ref_ones(p, wl),
                     1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_vco_adc_ctrl
`default_nettype wire
